prbs_gen_check: RTL and testbench
=================================

# prbs_gen_check

Parametrised pseudo-random bit-sequence generator and checker for link and datapath bring-up. It produces WIDTH bits per clock from one of four standard polynomials, and supports single-shot or continuous error injection. A checker receives a looped-back or external stream, acquires lock, counts bit errors, and drops lock on sustained errors. It is the generalised, single-clock successor to the fixed serial PRBS block and sits at the edge of a datapath under test.

## Interface
- WIDTH, 8: bits generated/checked per cycle; legal 1..64.
- LOCK_COUNT, 16: consecutive clean received words needed to assert lock; LOCK_COUNT*WIDTH >= 32 required.
- UNLOCK_COUNT, 4: consecutive errored words while locked that force loss of lock.
- CNT_W, 16: error counter width.
- Clock  in  1  single clock; all logic rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- enable  in  1  generator advances one word per cycle while high.
- mode  in  2  00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10 PRBS23 (x^23+x^18+1), 11 PRBS31 (x^31+x^28+1).
- inject_error  in  1  invert tx_data[WIDTH-1] of the word generated this cycle.
- clear_count  in  1  synchronous clear of err_count.
- tx_data  out  WIDTH  generated word; tx_data[WIDTH-1] is the earliest bit in time.
- tx_valid  out  1  tx_data valid.
- rx_data  in  WIDTH  received word, same bit order.
- rx_valid  in  1  rx_data valid.
- lock  out  1  checker locked.
- bit_error  out  1  one-cycle pulse per received word with at least one mismatch while locked.
- err_count  out  CNT_W  saturating count of mismatched bits while locked.

## Operation
- Serial LFSR step, length L and tap T per mode: b = s[L-1] ^ s[T-1]; s <= {s[L-2:0], b}; emitted bit = b. One word is WIDTH steps, computed combinationally in one cycle.
- Generator seed is all ones, loaded at reset and on any mode change.
- Generator: while enable=1, it registers the next word into tx_data and sets tx_valid=1. When enable=0, tx_valid=0, and tx_data and the LFSR hold.
- inject_error affects the output word only. The LFSR is not disturbed. It is ignored when enable=0.
- Checker history register H holds the last L received bits and shifts on every rx_valid word.
- Checker states:
  - HUNT (reset state): each bit is predicted self-synchronously from H and the earlier bits of the same word.
    - A word is clean if it has zero mismatches and its predicting history is non-zero.
    - A clean word increments good_cnt; any other word clears good_cnt.
    - When good_cnt reaches LOCK_COUNT, load the reference LFSR from H and go to LOCKED.
  - LOCKED: the reference LFSR advances WIDTH steps per rx_valid word and is compared bit by bit.
    - The mismatch popcount is added to err_count, saturating at 2^CNT_W-1.
    - bit_error pulses for any mismatch.
    - Errored words increment bad_cnt; a clean word clears bad_cnt.
    - When bad_cnt reaches UNLOCK_COUNT, go to HUNT and clear good_cnt/bad_cnt.
- A mode change from any state causes: checker to HUNT, counters cleared, H cleared, lock dropped. err_count is kept.
- clear_count has priority over an increment in the same cycle; that word's errors are discarded.
- err_count counts only in LOCKED. HUNT mismatches are not counted.
- rx_valid=0: checker state, H and all counters hold.

## Timing
- Reset values: tx_data=0, tx_valid=0, lock=0, bit_error=0, err_count=0, state HUNT, generator LFSR and reference LFSR all ones, H=0.
- Generator latency: the first word appears on tx_data one cycle after enable is first sampled high.
- Checker latency: lock, bit_error and err_count update on the cycle after the rx_valid word that causes the change.
- lock rises one cycle after the LOCK_COUNT-th clean word.
- lock falls one cycle after the UNLOCK_COUNT-th consecutive errored word. bit_error for that word is asserted in the same cycle.
- mode change: lock=0 on the next cycle. The generator's first new-mode word follows one cycle later, provided enable is high.
- Reset mid-operation takes effect immediately (asynchronous), including mid-word and mid-lock.

## Test plan
- Reset, enable=1, mode=00, WIDTH=8, tx looped to rx:
  - tx_data words are 8'h02 then 8'h0C.
  - lock rises after 16 clean words.
  - err_count=0 over 10000 cycles.
- After lock, a one-cycle inject_error pulse produces exactly one bit_error pulse, err_count=1, and lock stays 1.
- inject_error held for 4 words produces 4 bit_error pulses and err_count=4. lock falls after the 4th word and re-rises after 16 further clean words.
- Three bits of one rx word flipped externally while locked gives err_count += 3 and a single bit_error pulse.
- Each mode 00..11 switched live:
  - lock drops the next cycle.
  - The checker relocks in every mode.
  - err_count is preserved across the switch.
- CNT_W=4 with continuous errors: err_count saturates at 15. clear_count asserted in the same cycle as an error gives err_count=0.
- Reset asserted asynchronously while locked: all outputs return to reset values immediately.

Source files
------------

// File: rtl/prbs_gen_check_if.sv
// PRBS generator/checker bus: generator controls, tx/rx words and checker status.
// master drives controls and rx; slave (the block) drives tx and status.
interface prbs_gen_check_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             enable;
    logic [1:0]       mode;
    logic             inject_error;
    logic             clear_count;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             lock;
    logic             bit_error;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, mode, inject_error, clear_count,
        output rx_data, rx_valid,
        input  tx_data, tx_valid, lock, bit_error, err_count
    );

    modport slave (
        input  enable, mode, inject_error, clear_count,
        input  rx_data, rx_valid,
        output tx_data, tx_valid, lock, bit_error, err_count
    );
endinterface

// File: rtl/prbs_gen_check.sv
// PRBS7/15/23/31 word generator with error injection, plus locking bit-error checker.
// Ports: clk, rst_n (async low), bus (slave): enable/mode/inject/clear in, tx/rx words, lock/bit_error/err_count.
module prbs_gen_check #(
    parameter int WIDTH        = 8,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             rst_n,
    prbs_gen_check_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_COUNT - 1);
    localparam logic [SW-1:0] CNT_MAX   = SW'({CNT_W{1'b1}});

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state;
    logic [30:0]      gen_lfsr, gen_next;
    logic [30:0]      hist, hist_next;
    logic [30:0]      ref_lfsr, ref_next;
    logic [30:0]      g, h, r;
    logic [WIDTH-1:0] gen_word, ref_word, hunt_mis, lock_mis, inj_vec;
    logic [WIDTH-1:0] tx_data_q;
    logic             tx_valid_q, lock_q, bit_error_q;
    logic [CNT_W-1:0] err_q, err_inc;
    logic [SW-1:0]    err_sum;
    logic [1:0]       mode_q;
    logic             mode_seen, mode_chg, hunt_clean;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;

    // Feedback bit s[L-1] ^ s[T-1] for the selected polynomial.
    function automatic logic fb(input logic [30:0] s, input logic [1:0] m);
        unique case (m)
            2'b00:   return s[6] ^ s[5];
            2'b01:   return s[14] ^ s[13];
            2'b10:   return s[22] ^ s[17];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    // Keeps only the L live bits so unused upper bits never leak into state.
    function automatic logic [30:0] msk(input logic [1:0] m);
        unique case (m)
            2'b00:   return 31'h0000_007F;
            2'b01:   return 31'h0000_7FFF;
            2'b10:   return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++) popcnt = popcnt + PW'(v[i]);
    endfunction

    // MSB of each word is the earliest bit, so the step loop runs downward.
    always_comb begin
        g        = gen_lfsr;
        h        = hist;
        r        = ref_lfsr;
        gen_word = '0;
        ref_word = '0;
        hunt_mis = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            gen_word[i] = fb(g, bus.mode);
            g           = {g[29:0], gen_word[i]} & msk(bus.mode);
            hunt_mis[i] = bus.rx_data[i] ^ fb(h, bus.mode);
            h           = {h[29:0], bus.rx_data[i]} & msk(bus.mode);
            ref_word[i] = fb(r, bus.mode);
            r           = {r[29:0], ref_word[i]} & msk(bus.mode);
        end
        gen_next  = g;
        hist_next = h;
        ref_next  = r;
    end

    assign lock_mis   = bus.rx_data ^ ref_word;
    assign hunt_clean = (hunt_mis == '0) && (hist != '0);
    assign inj_vec    = WIDTH'(bus.inject_error) << (WIDTH - 1);
    assign mode_chg   = mode_seen && (bus.mode != mode_q);
    assign err_sum    = SW'(err_q) + SW'(popcnt(lock_mis));
    assign err_inc    = (err_sum > CNT_MAX) ? '1 : err_sum[CNT_W-1:0];

    // mode_seen masks the first edge after reset so the first word is not delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_lfsr   <= '1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            mode_q     <= 2'b00;
            mode_seen  <= 1'b0;
        end else begin
            mode_seen <= 1'b1;
            mode_q    <= bus.mode;
            if (mode_chg) begin
                gen_lfsr   <= '1;
                tx_valid_q <= 1'b0;
            end else if (bus.enable) begin
                gen_lfsr   <= gen_next;
                tx_data_q  <= gen_word ^ inj_vec;
                tx_valid_q <= 1'b1;
            end else begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            hist        <= '0;
            ref_lfsr    <= '1;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            lock_q      <= 1'b0;
            bit_error_q <= 1'b0;
            err_q       <= '0;
        end else begin
            bit_error_q <= 1'b0;
            if (bus.clear_count) begin
                err_q <= '0;
            end else if (bus.rx_valid && state == LOCKED && !mode_chg) begin
                err_q <= err_inc;
            end
            if (mode_chg) begin
                state    <= HUNT;
                hist     <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                lock_q   <= 1'b0;
            end else if (bus.rx_valid) begin
                hist <= hist_next;
                unique case (state)
                    HUNT: begin
                        if (!hunt_clean) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_LAST) begin
                            state    <= LOCKED;
                            lock_q   <= 1'b1;
                            ref_lfsr <= hist_next;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    default: begin
                        ref_lfsr <= ref_next;
                        if (lock_mis == '0) begin
                            bad_cnt <= '0;
                        end else begin
                            bit_error_q <= 1'b1;
                            if (bad_cnt == BAD_LAST) begin
                                state    <= HUNT;
                                lock_q   <= 1'b0;
                                bad_cnt  <= '0;
                                good_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.lock      = lock_q;
    assign bus.bit_error = bit_error_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_prbs_gen_check.sv
// Scoreboard bench for prbs_gen_check: tx looped to rx through a flip mask.
// Reference model works on bit recurrences; a second instance checks CNT_W=4 saturation.
module tb_prbs_gen_check;
    localparam int W  = 8;
    localparam int LC = 16;
    localparam int UC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs_gen_check_if #(.WIDTH(W), .CNT_W(16)) bus ();
    prbs_gen_check_if #(.WIDTH(W), .CNT_W(4))  bus2 ();

    logic [W-1:0] flip;
    assign bus.rx_data       = bus.tx_data ^ flip;
    assign bus.rx_valid      = bus.tx_valid;
    assign bus2.enable       = bus.enable;
    assign bus2.mode         = bus.mode;
    assign bus2.inject_error = bus.inject_error;
    assign bus2.clear_count  = bus.clear_count;
    assign bus2.rx_data      = bus.rx_data;
    assign bus2.rx_valid     = bus.rx_valid;

    prbs_gen_check #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    prbs_gen_check #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int be_pulses = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit lock;
        bit be;
        int e16;
        int e4;
    } exp_t;

    exp_t         chkq[$];
    logic [W-1:0] txq[$];
    exp_t         mon_e;

    bit           gh[$];
    bit           rh[$];
    bit           rq[$];
    int           mL, mT;
    logic [1:0]   mq;
    bit           m_lock;
    int           good, bad, e16, e4;
    logic [W-1:0] cur_tx;
    bit           cur_txv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    endtask

    function automatic void set_len(input logic [1:0] m);
        case (m)
            2'b00:   begin mL = 7;  mT = 6;  end
            2'b01:   begin mL = 15; mT = 14; end
            2'b10:   begin mL = 23; mT = 18; end
            default: begin mL = 31; mT = 28; end
        endcase
    endfunction

    function automatic void seed_gen();
        gh.delete();
        repeat (mL) gh.push_back(1'b1);
    endfunction

    function automatic void clear_hist();
        rh.delete();
        repeat (mL) rh.push_back(1'b0);
    endfunction

    // Each new bit is the bit L steps back xor the bit T steps back.
    function automatic logic [W-1:0] model_gen();
        logic [W-1:0] w;
        bit b;
        w = '0;
        for (int i = W - 1; i >= 0; i--) begin
            b = gh[gh.size() - mL] ^ gh[gh.size() - mT];
            gh.push_back(b);
            if (gh.size() > 31) gh.delete(0);
            w[i] = b;
        end
        return w;
    endfunction

    task automatic model_rx(input logic [W-1:0] w, output bit be);
        int mism;
        bit nz, b;
        mism = 0;
        nz = 1'b0;
        be = 1'b0;
        if (!m_lock) begin
            for (int k = 1; k <= mL; k++) nz |= rh[rh.size() - k];
            for (int i = W - 1; i >= 0; i--) begin
                b = rh[rh.size() - mL] ^ rh[rh.size() - mT];
                if (w[i] != b) mism++;
                rh.push_back(w[i]);
                if (rh.size() > 31) rh.delete(0);
            end
            if (mism == 0 && nz) begin
                good++;
                if (good == LC) begin
                    m_lock = 1'b1;
                    good = 0;
                    rq.delete();
                    for (int k = mL; k >= 1; k--) rq.push_back(rh[rh.size() - k]);
                end
            end else begin
                good = 0;
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                b = rq[rq.size() - mL] ^ rq[rq.size() - mT];
                rq.push_back(b);
                if (rq.size() > 31) rq.delete(0);
                if (w[i] != b) mism++;
                rh.push_back(w[i]);
                if (rh.size() > 31) rh.delete(0);
            end
            e16 = (e16 + mism > 65535) ? 65535 : e16 + mism;
            e4  = (e4 + mism > 15) ? 15 : e4 + mism;
            be = (mism != 0);
            if (mism != 0) begin
                bad++;
                if (bad == UC) begin
                    m_lock = 1'b0;
                    bad = 0;
                    good = 0;
                end
            end else begin
                bad = 0;
            end
        end
    endtask

    function automatic void model_reset();
        mq = bus.mode;
        set_len(mq);
        seed_gen();
        clear_hist();
        rq.delete();
        m_lock = 1'b0;
        good = 0;
        bad = 0;
        e16 = 0;
        e4 = 0;
        cur_tx = '0;
        cur_txv = 1'b0;
    endfunction

    // Drive one cycle of stimulus and queue the expected response of the next edge.
    task automatic step(input bit en, input bit inj, input logic [W-1:0] fl,
                        input bit clr, input logic [1:0] m);
        bit chg, be;
        exp_t e;
        bus.enable = en;
        bus.inject_error = inj;
        bus.clear_count = clr;
        bus.mode = m;
        flip = fl;
        chg = (m != mq);
        be = 1'b0;
        if (chg) begin
            set_len(m);
            m_lock = 1'b0;
            good = 0;
            bad = 0;
            clear_hist();
        end else if (cur_txv) begin
            model_rx(cur_tx ^ fl, be);
        end
        if (clr) begin
            e16 = 0;
            e4 = 0;
        end
        e = '{cyc + 1, m_lock, be, e16, e4};
        chkq.push_back(e);
        mq = m;
        if (chg) begin
            seed_gen();
            cur_txv = 1'b0;
        end else if (en) begin
            cur_tx = model_gen() ^ {inj, {(W-1){1'b0}}};
            cur_txv = 1'b1;
            txq.push_back(cur_tx);
        end else begin
            cur_txv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n, input logic [1:0] m);
        repeat (n) step(1'b1, 1'b0, '0, 1'b0, m);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_data"}, bus.tx_data, 0);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_lock"}, bus.lock, 0);
        check({tag, "_bit_error"}, bus.bit_error, 0);
        check({tag, "_err_count"}, bus.err_count, 0);
        check({tag, "_err_count4"}, bus2.err_count, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        txq.delete();
        chkq.delete();
        bus.enable = 1'b0;
        bus.inject_error = 1'b0;
        bus.clear_count = 1'b0;
        flip = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bit_error) be_pulses++;
            if (bus.tx_valid) begin
                if (txq.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: tx_valid=1 data=%0h with no expected word", bus.tx_data);
                end else begin
                    check("tx_data", bus.tx_data, txq.pop_front());
                end
            end
            while (chkq.size() > 0 && chkq[0].cyc <= cyc) begin
                mon_e = chkq.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_checks++;
                    $display("FAIL chk_stale: entry for cycle %0d seen at cycle %0d", mon_e.cyc, cyc);
                end else begin
                    check("lock", bus.lock, mon_e.lock);
                    check("bit_error", bus.bit_error, mon_e.be);
                    check("err_count", bus.err_count, mon_e.e16);
                    check("err_count_w4", bus2.err_count, mon_e.e4);
                    check("lock_w4", bus2.lock, mon_e.lock);
                end
            end
        end
    end

    initial begin
        logic [1:0] mm;
        bit en, inj, clr;
        logic [W-1:0] fl;
        flip = '0;
        bus.enable = 1'b0;
        bus.mode = 2'b00;
        bus.inject_error = 1'b0;
        bus.clear_count = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        step(1'b1, 1'b0, '0, 1'b0, 2'b00);
        check("first_word", bus.tx_data, 8'h02);
        step(1'b1, 1'b0, '0, 1'b0, 2'b00);
        check("second_word", bus.tx_data, 8'h0C);
        clean(30, 2'b00);
        check("lock_mode0", bus.lock, 1);
        clean(10000, 2'b00);
        check("long_run_err", bus.err_count, 0);

        be_pulses = 0;
        step(1'b1, 1'b1, '0, 1'b0, 2'b00);
        clean(20, 2'b00);
        check("inj1_pulses", be_pulses, 1);
        check("inj1_err", bus.err_count, 1);
        check("inj1_lock", bus.lock, 1);

        be_pulses = 0;
        repeat (4) step(1'b1, 1'b1, '0, 1'b0, 2'b00);
        step(1'b1, 1'b0, '0, 1'b0, 2'b00);
        check("inj4_unlock", bus.lock, 0);
        clean(25, 2'b00);
        check("inj4_pulses", be_pulses, 4);
        check("inj4_err", bus.err_count, 5);
        check("inj4_relock", bus.lock, 1);

        be_pulses = 0;
        step(1'b1, 1'b0, 8'h13, 1'b0, 2'b00);
        clean(5, 2'b00);
        check("flip3_err", bus.err_count, 8);
        check("flip3_pulses", be_pulses, 1);
        check("flip3_lock", bus.lock, 1);

        for (int k = 1; k <= 4; k++) begin
            mm = 2'(k);
            step(1'b1, 1'b0, '0, 1'b0, mm);
            check("mode_drop", bus.lock, 0);
            clean(80, mm);
            check("mode_relock", bus.lock, 1);
            check("mode_err_kept", bus.err_count, 8);
        end

        repeat (4) step(1'b1, 1'b0, 8'hFF, 1'b0, 2'b00);
        step(1'b1, 1'b0, '0, 1'b0, 2'b00);
        check("burst_err", bus.err_count, 40);
        check("burst_sat4", bus2.err_count, 15);
        check("burst_unlock", bus.lock, 0);
        clean(30, 2'b00);
        step(1'b1, 1'b0, 8'h01, 1'b1, 2'b00);
        step(1'b1, 1'b0, '0, 1'b0, 2'b00);
        check("clear_pri", bus.err_count, 0);
        check("clear_pri4", bus2.err_count, 0);

        mm = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom % 8) != 0;
            inj = ($urandom % 64) == 0;
            fl  = (($urandom % 64) == 0) ? W'($urandom) : '0;
            clr = ($urandom % 300) == 0;
            if (($urandom % 500) == 0) mm = 2'($urandom);
            step(en, inj, fl, clr, mm);
        end

        clean(60, mm);
        check("pre_reset_lock", bus.lock, 1);
        async_reset();
        clean(40, mm);
        check("post_reset_lock", bus.lock, 1);

        repeat (3) step(1'b0, 1'b0, '0, 1'b0, mm);
        @(negedge clk);
        #1;
        check("txq_drained", txq.size(), 0);
        check("chkq_drained", chkq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
